// File: rtl/udma_cfg_arbiter_pkg.sv
// Shared types and constants for the uDMA peripheral configuration-bus arbiter.
// Imported by the arbiter, its round-robin picker and the requester interface.
package udma_cfg_arbiter_pkg;

    localparam int CFG_ADDR_W = 5;
    localparam int CFG_DATA_W = 32;

    typedef enum logic [1:0] {
        CFG_IDLE   = 2'd0,
        CFG_ACCESS = 2'd1,
        CFG_RESP   = 2'd2
    } cfg_arb_state_e;

    // Index width that stays legal for a single requester.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/udma_cfg_arbiter_if.sv
// Requester-side bus of the config arbiter: flattened per-requester request
// fields in, one-hot accept and response out.
interface udma_cfg_arbiter_if #(
    parameter int N_REQ  = 2,
    parameter int SLOT_W = 3
);
    import udma_cfg_arbiter_pkg::*;

    logic [N_REQ-1:0]            req_valid_i;
    logic [N_REQ-1:0]            req_ready_o;
    logic [N_REQ*SLOT_W-1:0]     req_slot_i;
    logic [N_REQ*CFG_ADDR_W-1:0] req_addr_i;
    logic [N_REQ-1:0]            req_rwn_i;
    logic [N_REQ*CFG_DATA_W-1:0] req_wdata_i;
    logic [N_REQ-1:0]            rsp_valid_o;
    logic [CFG_DATA_W-1:0]       rsp_rdata_o;
    logic                        rsp_err_o;

    modport master (
        output req_valid_i, req_slot_i, req_addr_i, req_rwn_i, req_wdata_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

    modport slave (
        input  req_valid_i, req_slot_i, req_addr_i, req_rwn_i, req_wdata_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o
    );

endinterface

// File: rtl/udma_rr_arbiter.sv
// Combinational round-robin picker: first set request searching upward from
// ptr+1 with wrap. The pointer itself lives in the parent.
module udma_rr_arbiter
    import udma_cfg_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found_s;
    logic [IDX_W-1:0] k_s;

    // Rotating priority search starting just after the last winner.
    always_comb begin
        grant   = '0;
        idx     = '0;
        found_s = 1'b0;
        k_s     = '0;
        for (int i = 1; i <= N; i++) begin
            k_s = IDX_W'((int'(ptr) + i) % N);
            if (!found_s && req[k_s]) begin
                found_s    = 1'b1;
                grant[k_s] = 1'b1;
                idx        = k_s;
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/udma_cfg_arbiter.sv
// Round-robin arbiter sharing the uDMA peripheral config bus between N_REQ
// requesters; one transaction in flight, with bad-slot and timeout errors.
module udma_cfg_arbiter
    import udma_cfg_arbiter_pkg::*;
#(
    parameter int N_REQ       = 2,
    parameter int N_PERIPHS   = 8,
    parameter int SLOT_W      = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                            sys_clk_i,
    input  logic                            rst_i,
    udma_cfg_arbiter_if.slave               bus,
    output logic [CFG_DATA_W-1:0]           periph_data_to_o,
    output logic [CFG_ADDR_W-1:0]           periph_addr_o,
    output logic                            periph_rwn_o,
    output logic [N_PERIPHS-1:0]            periph_valid_o,
    input  logic [N_PERIPHS-1:0]            periph_ready_i,
    input  logic [N_PERIPHS*CFG_DATA_W-1:0] periph_data_from_i,
    output logic                            busy_o
);

    localparam int IDX_W   = idx_width(N_REQ);
    localparam int CNT_W   = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? (TIMEOUT_CYC - 1) : 0;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cfg_arb_state_e        state_r;
    logic [IDX_W-1:0]      rr_ptr_r;
    logic [N_REQ-1:0]      gnt_oh_r;
    logic [CNT_W-1:0]      cnt_r;

    logic [N_REQ-1:0]      grant_s;
    logic [IDX_W-1:0]      gidx_s;
    logic [SLOT_W-1:0]     sel_slot_s;
    logic [CFG_ADDR_W-1:0] sel_addr_s;
    logic                  sel_rwn_s;
    logic [CFG_DATA_W-1:0] sel_wdata_s;
    logic                  sel_legal_s;
    logic [N_PERIPHS-1:0]  sel_oh_s;
    logic                  slot_rdy_s;
    logic [CFG_DATA_W-1:0] slot_rdata_s;
    logic                  timeout_s;

    udma_rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req   (bus.req_valid_i),
        .ptr   (rr_ptr_r),
        .grant (grant_s),
        .idx   (gidx_s)
    );

    // AND-OR mux of the granted requester's fields plus slot decode.
    always_comb begin
        sel_slot_s  = '0;
        sel_addr_s  = '0;
        sel_rwn_s   = 1'b0;
        sel_wdata_s = '0;
        sel_oh_s    = '0;
        for (int r = 0; r < N_REQ; r++) begin
            sel_slot_s  = sel_slot_s  | (bus.req_slot_i[r*SLOT_W +: SLOT_W] & {SLOT_W{grant_s[r]}});
            sel_addr_s  = sel_addr_s  | (bus.req_addr_i[r*CFG_ADDR_W +: CFG_ADDR_W] & {CFG_ADDR_W{grant_s[r]}});
            sel_rwn_s   = sel_rwn_s   | (bus.req_rwn_i[r] & grant_s[r]);
            sel_wdata_s = sel_wdata_s | (bus.req_wdata_i[r*CFG_DATA_W +: CFG_DATA_W] & {CFG_DATA_W{grant_s[r]}});
        end
        sel_legal_s = (int'(sel_slot_s) < N_PERIPHS);
        for (int p = 0; p < N_PERIPHS; p++) begin
            sel_oh_s[p] = (int'(sel_slot_s) == p);
        end
    end

    // The registered one-hot strobe doubles as the ready/data select, so
    // other slots' ready and data never reach the response path.
    always_comb begin
        slot_rdy_s   = |(periph_ready_i & periph_valid_o);
        slot_rdata_s = '0;
        for (int p = 0; p < N_PERIPHS; p++) begin
            slot_rdata_s = slot_rdata_s |
                           (periph_data_from_i[p*CFG_DATA_W +: CFG_DATA_W] & {CFG_DATA_W{periph_valid_o[p]}});
        end
        timeout_s = (TIMEOUT_CYC > 0) && (cnt_r == CNT_W'(TO_LAST));
    end

    // Accept is only offered while idle.
    always_comb begin
        if (state_r == CFG_IDLE) begin
            bus.req_ready_o = grant_s;
        end else begin
            bus.req_ready_o = '0;
        end
    end

    assign busy_o = (state_r != CFG_IDLE);

    // Transaction FSM with its capture registers and timeout counter.
    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_r          <= CFG_IDLE;
            rr_ptr_r         <= IDX_W'(N_REQ - 1);
            gnt_oh_r         <= '0;
            cnt_r            <= '0;
            periph_valid_o   <= '0;
            periph_addr_o    <= '0;
            periph_data_to_o <= '0;
            periph_rwn_o     <= 1'b0;
            bus.rsp_valid_o  <= '0;
            bus.rsp_rdata_o  <= '0;
            bus.rsp_err_o    <= 1'b0;
        end else begin
            case (state_r)
                CFG_IDLE: begin
                    bus.rsp_valid_o <= '0;
                    bus.rsp_rdata_o <= '0;
                    bus.rsp_err_o   <= 1'b0;
                    cnt_r           <= '0;
                    if (|bus.req_valid_i) begin
                        rr_ptr_r <= gidx_s;
                        gnt_oh_r <= grant_s;
                        if (sel_legal_s) begin
                            periph_valid_o   <= sel_oh_s;
                            periph_addr_o    <= sel_addr_s;
                            periph_data_to_o <= sel_wdata_s;
                            periph_rwn_o     <= sel_rwn_s;
                            state_r          <= CFG_ACCESS;
                        end else begin
                            bus.rsp_valid_o <= grant_s;
                            bus.rsp_err_o   <= 1'b1;
                            state_r         <= CFG_RESP;
                        end
                    end else begin
                        state_r <= CFG_IDLE;
                    end
                end
                CFG_ACCESS: begin
                    // Ready wins over a timeout landing on the same cycle.
                    if (slot_rdy_s) begin
                        periph_valid_o  <= '0;
                        bus.rsp_valid_o <= gnt_oh_r;
                        bus.rsp_rdata_o <= periph_rwn_o ? slot_rdata_s : '0;
                        bus.rsp_err_o   <= 1'b0;
                        state_r         <= CFG_RESP;
                    end else if (timeout_s) begin
                        periph_valid_o  <= '0;
                        bus.rsp_valid_o <= gnt_oh_r;
                        bus.rsp_rdata_o <= '0;
                        bus.rsp_err_o   <= 1'b1;
                        state_r         <= CFG_RESP;
                    end else if (cnt_r != CNT_MAX) begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end else begin
                        cnt_r <= cnt_r;
                    end
                end
                CFG_RESP: begin
                    bus.rsp_valid_o <= '0;
                    bus.rsp_rdata_o <= '0;
                    bus.rsp_err_o   <= 1'b0;
                    cnt_r           <= '0;
                    state_r         <= CFG_IDLE;
                end
                default: begin
                    periph_valid_o  <= '0;
                    bus.rsp_valid_o <= '0;
                    bus.rsp_rdata_o <= '0;
                    bus.rsp_err_o   <= 1'b0;
                    cnt_r           <= '0;
                    state_r         <= CFG_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_udma_cfg_arbiter.sv
// Bench for udma_cfg_arbiter: directed scenarios then random traffic, every
// cycle compared against a transaction-level model of the arbitration rules.
module tb_udma_cfg_arbiter;
    import udma_cfg_arbiter_pkg::*;

    localparam int N_REQ       = 2;
    localparam int N_PERIPHS   = 5;
    localparam int SLOT_W      = 3;
    localparam int TIMEOUT_CYC = 8;
    localparam int NEVER       = 99;

    logic                            sys_clk_i = 1'b0;
    logic                            rst_i;
    logic [CFG_DATA_W-1:0]           periph_data_to_o;
    logic [CFG_ADDR_W-1:0]           periph_addr_o;
    logic                            periph_rwn_o;
    logic [N_PERIPHS-1:0]            periph_valid_o;
    logic [N_PERIPHS-1:0]            periph_ready_i;
    logic [N_PERIPHS*CFG_DATA_W-1:0] periph_data_from_i;
    logic                            busy_o;

    udma_cfg_arbiter_if #(.N_REQ(N_REQ), .SLOT_W(SLOT_W)) bus ();

    udma_cfg_arbiter #(
        .N_REQ(N_REQ), .N_PERIPHS(N_PERIPHS), .SLOT_W(SLOT_W), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .sys_clk_i          (sys_clk_i),
        .rst_i              (rst_i),
        .bus                (bus.slave),
        .periph_data_to_o   (periph_data_to_o),
        .periph_addr_o      (periph_addr_o),
        .periph_rwn_o       (periph_rwn_o),
        .periph_valid_o     (periph_valid_o),
        .periph_ready_i     (periph_ready_i),
        .periph_data_from_i (periph_data_from_i),
        .busy_o             (busy_o)
    );

    always #5 sys_clk_i = ~sys_clk_i;

    int n_checks = 0;
    int n_pass   = 0;

    // Pending request per requester (held until the model sees it accepted).
    bit          p_valid [N_REQ];
    int          p_slot  [N_REQ];
    int          p_addr  [N_REQ];
    bit          p_rwn   [N_REQ];
    logic [31:0] p_wdata [N_REQ];
    logic [31:0] p_rdata [N_REQ];
    int          p_lat   [N_REQ];
    int          refill  [N_REQ];

    // Reference model: phase 0 idle, 1 strobing a slot, 2 responding.
    int          m_phase, m_wait, m_last;
    int          c_owner, c_slot, c_addr, c_lat;
    bit          c_rwn;
    logic [31:0] c_wdata, c_rdata, e_rdata;
    bit          e_err;
    bit          rand_mode;
    int          grant_log[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic new_req(input int r, input int slot, input int addr, input bit rwn,
                           input logic [31:0] wdata, input logic [31:0] rdata, input int lat);
        p_valid[r] = 1'b1;
        p_slot[r]  = slot;
        p_addr[r]  = addr;
        p_rwn[r]   = rwn;
        p_wdata[r] = wdata;
        p_rdata[r] = rdata;
        p_lat[r]   = lat;
    endtask

    function automatic int pick();
        for (int i = 1; i <= N_REQ; i++) begin
            if (p_valid[(m_last + i) % N_REQ]) return (m_last + i) % N_REQ;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_phase = 0;
        m_wait  = 0;
        m_last  = N_REQ - 1;
        for (int r = 0; r < N_REQ; r++) begin
            p_valid[r] = 1'b0;
            refill[r]  = 0;
        end
    endtask

    task automatic step();
        logic [N_PERIPHS-1:0]            rdy;
        logic [N_PERIPHS*CFG_DATA_W-1:0] dat;
        logic [63:0]                     exp_ready;
        int                              g;
        @(negedge sys_clk_i);
        if (rand_mode) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (!p_valid[r]) begin
                    if ($urandom_range(0, 2) == 0)
                        new_req(r, int'($urandom_range(0, 7)), int'($urandom_range(0, 31)),
                                $urandom_range(0, 1) == 1, $urandom, $urandom, int'($urandom_range(0, 10)));
                end else if ($urandom_range(0, 24) == 0) begin
                    p_valid[r] = 1'b0;
                end
            end
        end
        for (int r = 0; r < N_REQ; r++) begin
            bus.req_valid_i[r] = p_valid[r];
            bus.req_slot_i[r*SLOT_W +: SLOT_W]             = SLOT_W'(p_slot[r]);
            bus.req_addr_i[r*CFG_ADDR_W +: CFG_ADDR_W]     = CFG_ADDR_W'(p_addr[r]);
            bus.req_rwn_i[r]                               = p_rwn[r];
            bus.req_wdata_i[r*CFG_DATA_W +: CFG_DATA_W]    = p_wdata[r];
        end
        for (int s = 0; s < N_PERIPHS; s++) begin
            rdy[s] = ($urandom_range(0, 1) == 1);
            dat[s*CFG_DATA_W +: CFG_DATA_W] = $urandom;
        end
        if (m_phase == 1) begin
            rdy[c_slot] = (m_wait == c_lat);
            dat[c_slot*CFG_DATA_W +: CFG_DATA_W] = c_rdata;
        end
        periph_ready_i     = rdy;
        periph_data_from_i = dat;
        #1;
        check_eq("busy", busy_o, m_phase != 0);
        check_eq("periph_valid", periph_valid_o, (m_phase == 1) ? (64'd1 << c_slot) : 64'd0);
        if (m_phase == 1) begin
            check_eq("periph_addr", periph_addr_o, c_addr);
            check_eq("periph_wdata", periph_data_to_o, c_wdata);
            check_eq("periph_rwn", periph_rwn_o, c_rwn);
        end
        check_eq("rsp_valid", bus.rsp_valid_o, (m_phase == 2) ? (64'd1 << c_owner) : 64'd0);
        check_eq("rsp_rdata", bus.rsp_rdata_o, (m_phase == 2) ? e_rdata : 32'd0);
        check_eq("rsp_err", bus.rsp_err_o, (m_phase == 2) ? e_err : 1'b0);
        g = (m_phase == 0) ? pick() : -1;
        exp_ready = (g >= 0) ? (64'd1 << g) : 64'd0;
        check_eq("req_ready", bus.req_ready_o, exp_ready);
        if (bus.req_ready_o != '0) grant_log.push_back(bus.req_ready_o[1] ? 1 : 0);
        case (m_phase)
            0: if (g >= 0) begin
                c_owner = g;       c_slot  = p_slot[g];  c_addr = p_addr[g];
                c_rwn   = p_rwn[g]; c_wdata = p_wdata[g]; c_rdata = p_rdata[g];
                c_lat   = p_lat[g];
                p_valid[g] = 1'b0;
                m_last = g;
                m_wait = 0;
                if (c_slot < N_PERIPHS) m_phase = 1;
                else begin
                    m_phase = 2; e_err = 1'b1; e_rdata = 32'd0;
                end
                if (refill[g] > 0) begin
                    refill[g]--;
                    new_req(g, int'($urandom_range(0, N_PERIPHS - 1)), int'($urandom_range(0, 31)),
                            1'b0, $urandom, $urandom, int'($urandom_range(0, 3)));
                end
            end
            1: if (m_wait == c_lat) begin
                m_phase = 2; e_err = 1'b0; e_rdata = c_rwn ? c_rdata : 32'd0;
            end else if (m_wait == TIMEOUT_CYC - 1) begin
                m_phase = 2; e_err = 1'b1; e_rdata = 32'd0;
            end else begin
                m_wait++;
            end
            default: m_phase = 0;
        endcase
    endtask

    task automatic drain(input string tag);
        int budget = 200;
        while (budget > 0 && (p_valid[0] || p_valid[1] || m_phase != 0)) begin
            step();
            budget--;
        end
        check_eq(tag, budget > 0, 1'b1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        bus.req_valid_i = '0; bus.req_slot_i = '0; bus.req_addr_i = '0;
        bus.req_rwn_i   = '0; bus.req_wdata_i = '0;
        periph_ready_i  = '0; periph_data_from_i = '0;
        rand_mode = 1'b0;
        model_reset();
        repeat (3) @(negedge sys_clk_i);
        check_eq("rst_busy", busy_o, 1'b0);
        check_eq("rst_periph_valid", periph_valid_o, 5'd0);
        check_eq("rst_periph_addr", periph_addr_o, 5'd0);
        check_eq("rst_periph_wdata", periph_data_to_o, 32'd0);
        check_eq("rst_rsp_valid", bus.rsp_valid_o, 2'd0);
        check_eq("rst_rsp_rdata", bus.rsp_rdata_o, 32'd0);
        check_eq("rst_rsp_err", bus.rsp_err_o, 1'b0);
        rst_i = 1'b0;

        // Read slot 2 with zero-wait ready.
        new_req(0, 2, 4, 1'b1, 32'h0, 32'hCAFE_0001, 0);
        drain("read_done");
        // Illegal slot from requester 1.
        new_req(1, 6, 3, 1'b0, 32'h1234_5678, 32'h0, 0);
        drain("badslot_done");
        // Both requesters held valid, four writes each.
        grant_log.delete();
        new_req(0, 1, 7, 1'b0, 32'hA0A0_0000, 32'h0, 1);
        new_req(1, 3, 9, 1'b0, 32'hB0B0_0000, 32'h0, 2);
        refill[0] = 3;
        refill[1] = 3;
        drain("alt_done");
        check_eq("alt_count", grant_log.size(), 8);
        foreach (grant_log[i]) check_eq("alt_grant", grant_log[i], i % 2);
        // Timeout, then a normal request.
        new_req(0, 3, 1, 1'b1, 32'h0, 32'hDEAD_BEEF, NEVER);
        drain("timeout_done");
        new_req(1, 4, 2, 1'b1, 32'h0, 32'h0BAD_F00D, 1);
        drain("after_timeout_done");
        // Ready on the last cycle before timeout.
        new_req(0, 1, 5, 1'b1, 32'h0, 32'h600D_0007, TIMEOUT_CYC - 1);
        drain("late_ready_done");

        // Reset while strobing a slot.
        new_req(1, 2, 0, 1'b0, 32'h5555_AAAA, 32'h0, NEVER);
        repeat (3) step();
        #2;
        rst_i = 1'b1;
        bus.req_valid_i = '0;
        #1;
        check_eq("midrst_periph_valid", periph_valid_o, 5'd0);
        check_eq("midrst_busy", busy_o, 1'b0);
        check_eq("midrst_rsp_valid", bus.rsp_valid_o, 2'd0);
        repeat (2) @(negedge sys_clk_i);
        rst_i = 1'b0;
        model_reset();
        new_req(0, 0, 1, 1'b1, 32'h0, 32'h1111_2222, 0);
        new_req(1, 4, 1, 1'b1, 32'h0, 32'h3333_4444, 0);
        drain("post_rst_done");

        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0;
        drain("random_done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
